// File: rtl/uart_io_seq.sv
// uart_io_seq: UART-side sequencer: FIFO echo (plain / upper-case), periodic message bursts, idle/flush.
// Latency: RX strobe to tx_en is 2 cycles on an empty FIFO; a message tick gives tx_en 2+ cycles later.
// Backpressure: a byte launches only when tx_rdy=1 in IDLE; SEND+HOLD limit output to one byte per 3 cycles.
module uart_io_seq #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MSG_MAX    = 32,
  parameter int PERIOD     = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic [DATA_W-1:0]           din,
  input  logic                        d_rdy,
  input  logic                        tx_rdy,
  input  logic                        msg_we,
  input  logic [$clog2(MSG_MAX)-1:0]  msg_addr,
  input  logic [DATA_W-1:0]           msg_wdata,
  input  logic [$clog2(MSG_MAX):0]    msg_len,
  output logic [DATA_W-1:0]           dout,
  output logic                        tx_en,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        ovf,
  output logic                        busy
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int AW = $clog2(MSG_MAX);
  localparam int CW = $clog2(PERIOD);

  localparam logic [1:0] M_ECHO  = 2'd0;
  localparam logic [1:0] M_MSG   = 2'd1;
  localparam logic [1:0] M_UPPER = 2'd2;
  localparam logic [1:0] M_IDLE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t            r_state;
  logic              r_src_msg;
  logic [1:0]        r_mode_d;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [DATA_W-1:0] r_msg  [MSG_MAX];
  logic [FW-1:0]     r_wr_ptr;
  logic [FW-1:0]     r_rd_ptr;
  logic [FW:0]       r_cnt;
  logic              r_ovf;
  logic              r_busy;
  logic [AW:0]       r_idx;
  logic [CW-1:0]     r_per;
  logic [DATA_W-1:0] r_dout;
  logic              r_tx_en;

  logic              w_echo;
  logic              w_enter_msg;
  logic              w_flush;
  logic [AW:0]       w_len_eff;
  logic [AW:0]       w_idx_nxt;
  logic              w_tick;
  logic              w_fifo_avail;
  logic              w_msg_avail;
  logic              w_launch;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_fifo_byte;
  logic [DATA_W-1:0] w_conv_byte;
  logic [DATA_W-1:0] w_msg_byte;

  assign w_echo       = (mode == M_ECHO) || (mode == M_UPPER);
  assign w_enter_msg  = (mode == M_MSG) && (r_mode_d != M_MSG);
  // Entering MSG or IDLE discards buffered echo traffic; ECHO<->UPPER keeps it.
  assign w_flush      = w_enter_msg || ((mode == M_IDLE) && (r_mode_d != M_IDLE));
  assign w_len_eff    = (msg_len > (AW+1)'(MSG_MAX)) ? (AW+1)'(MSG_MAX) : msg_len;
  assign w_idx_nxt    = r_idx + (AW+1)'(1);
  assign w_tick       = (mode == M_MSG) && !w_enter_msg && (r_per == CW'(PERIOD-1));
  assign w_fifo_avail = w_echo && (r_cnt != '0);
  assign w_msg_avail  = (mode == M_MSG) && r_busy && (r_idx < w_len_eff);
  assign w_launch     = (r_state == S_IDLE) && tx_rdy && (w_fifo_avail || w_msg_avail);
  assign w_full       = (r_cnt == (FW+1)'(FIFO_DEPTH));
  // The byte read in IDLE leaves the FIFO during its SEND cycle.
  assign w_pop        = (r_state == S_SEND) && !r_src_msg && (r_cnt != '0);
  assign w_push       = d_rdy && w_echo && (!w_full || w_pop);
  assign w_drop       = d_rdy && w_echo && w_full && !w_pop;
  assign w_fifo_byte  = r_fifo[r_rd_ptr];
  assign w_msg_byte   = r_msg[r_idx[AW-1:0]];
  // Lower-case ASCII is folded to upper-case on the way out, only in ECHO_UPPER.
  assign w_conv_byte  = ((mode == M_UPPER) && (w_fifo_byte >= DATA_W'('h61)) &&
                         (w_fifo_byte <= DATA_W'('h7A))) ? (w_fifo_byte - DATA_W'('h20)) : w_fifo_byte;

  assign dout     = r_dout;
  assign tx_en    = r_tx_en;
  assign fifo_cnt = r_cnt;
  assign ovf      = r_ovf;
  assign busy     = r_busy;

  // Message RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (msg_we) r_msg[msg_addr] <= msg_wdata;
  end

  // Echo FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= din;
  end

  // Echo FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
        if (w_push && !w_pop)      r_cnt <= r_cnt + (FW+1)'(1);
        else if (!w_push && w_pop) r_cnt <= r_cnt - (FW+1)'(1);
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Mode history, period counter and message-burst tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_d <= M_ECHO;
      r_per    <= '0;
      r_busy   <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_mode_d <= mode;
      if ((mode != M_MSG) || w_enter_msg || (r_per == CW'(PERIOD-1))) r_per <= '0;
      else                                                          r_per <= r_per + CW'(1);
      if (mode != M_MSG) begin
        r_busy <= 1'b0;
      end else if (w_tick && !r_busy && (w_len_eff != '0)) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
      end else if ((r_state == S_SEND) && r_src_msg) begin
        r_idx <= w_idx_nxt;
        if (w_idx_nxt >= w_len_eff) r_busy <= 1'b0;
      end else if (r_busy && (r_idx >= w_len_eff)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Transmit FSM: IDLE picks a byte, SEND strobes it, HOLD spaces strobes apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_src_msg <= 1'b0;
      r_dout    <= '0;
      r_tx_en   <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state   <= S_SEND;
            r_tx_en   <= 1'b1;
            r_src_msg <= (mode == M_MSG);
            r_dout    <= (mode == M_MSG) ? w_msg_byte : w_conv_byte;
          end
        end
        S_SEND:  r_state <= S_HOLD;
        S_HOLD:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_seq.sv
// tb_uart_io_seq: directed checks of echo, upper-case echo, flush, overflow, message bursts, aborts, flow control, reset.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
// A passive monitor logs every tx_en byte with its cycle number for the scenario tasks to inspect.
module tb_uart_io_seq;
  localparam int DATA_W = 8, FIFO_DEPTH = 4, MSG_MAX = 32, PERIOD = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode;
  logic [7:0] din;
  logic       d_rdy;
  logic       tx_rdy;
  logic       msg_we;
  logic [4:0] msg_addr;
  logic [7:0] msg_wdata;
  logic [5:0] msg_len;
  logic [7:0] dout;
  logic       tx_en;
  logic [2:0] fifo_cnt;
  logic       ovf;
  logic       busy;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int n_consec = 0;
  logic prev_en = 1'b0;
  logic [7:0] q_b[$];
  int         q_c[$];

  uart_io_seq #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MSG_MAX(MSG_MAX), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .d_rdy(d_rdy), .tx_rdy(tx_rdy),
    .msg_we(msg_we), .msg_addr(msg_addr), .msg_wdata(msg_wdata), .msg_len(msg_len),
    .dout(dout), .tx_en(tx_en), .fifo_cnt(fifo_cnt), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      q_b.push_back(dout);
      q_c.push_back(cyc);
      if (prev_en === 1'b1) n_consec++;
    end
    prev_en = tx_en;
  end

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_q;
    q_b.delete();
    q_c.delete();
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tot++; if (dout !== 8'h00)    $display("FAIL reset_dout: got %0h want 0", dout); else n_pass++;
    n_tot++; if (tx_en !== 1'b0)    $display("FAIL reset_tx_en: got %0b want 0", tx_en); else n_pass++;
    n_tot++; if (fifo_cnt !== 3'd0) $display("FAIL reset_fifo_cnt: got %0d want 0", fifo_cnt); else n_pass++;
    n_tot++; if (ovf !== 1'b0)      $display("FAIL reset_ovf: got %0b want 0", ovf); else n_pass++;
    n_tot++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_echo;
    logic [7:0] v [3] = '{8'h41, 8'h62, 8'h0D};
    int s [3];
    logic [7:0] gb;
    int gc;
    mode = 2'd0; tx_rdy = 1'b1;
    clear_q();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      din = v[i]; d_rdy = 1'b1; s[i] = cyc;
      @(negedge clk);
      d_rdy = 1'b0;
      repeat (5) @(negedge clk);
    end
    n_tot++; if (q_b.size() !== 3) $display("FAIL echo_count: got %0d want 3", q_b.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      gb = (i < q_b.size()) ? q_b[i] : 8'hxx;
      gc = (i < q_c.size()) ? q_c[i] : -1;
      n_tot++; if (gb !== v[i])     $display("FAIL echo_byte%0d: got %0h want %0h", i, gb, v[i]); else n_pass++;
      n_tot++; if (gc !== s[i] + 2) $display("FAIL echo_latency%0d: got cycle %0d want %0d", i, gc, s[i] + 2); else n_pass++;
    end
    n_tot++; if (fifo_cnt !== 3'd0) $display("FAIL echo_fifo_empty: got %0d want 0", fifo_cnt); else n_pass++;
  endtask

  task automatic test_upper;
    logic [7:0] v [4] = '{8'h61, 8'h7A, 8'h7B, 8'h40};
    logic [7:0] e [4] = '{8'h41, 8'h5A, 8'h7B, 8'h40};
    logic [7:0] gb;
    mode = 2'd2; tx_rdy = 1'b1;
    clear_q();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = v[i]; d_rdy = 1'b1;
      @(negedge clk);
      d_rdy = 1'b0;
      repeat (4) @(negedge clk);
    end
    n_tot++; if (q_b.size() !== 4) $display("FAIL upper_count: got %0d want 4", q_b.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      gb = (i < q_b.size()) ? q_b[i] : 8'hxx;
      n_tot++; if (gb !== e[i]) $display("FAIL upper_byte%0d: got %0h want %0h", i, gb, e[i]); else n_pass++;
    end
  endtask

  task automatic test_idle_flush;
    logic [7:0] gb;
    mode = 2'd0; tx_rdy = 1'b0;
    clear_q();
    @(negedge clk);
    din = 8'h61; d_rdy = 1'b1;
    @(negedge clk);
    d_rdy = 1'b0; mode = 2'd2;
    @(negedge clk);
    n_tot++; if (fifo_cnt !== 3'd1) $display("FAIL keep_on_0_to_2: got %0d want 1", fifo_cnt); else n_pass++;
    tx_rdy = 1'b1;
    repeat (4) @(negedge clk);
    tx_rdy = 1'b0;
    @(negedge clk);
    gb = (q_b.size() > 0) ? q_b[0] : 8'hxx;
    n_tot++; if (gb !== 8'h41) $display("FAIL convert_after_switch: got %0h want 41", gb); else n_pass++;
    din = 8'h01; d_rdy = 1'b1;
    @(negedge clk);
    din = 8'h02;
    @(negedge clk);
    d_rdy = 1'b0;
    @(negedge clk);
    n_tot++; if (fifo_cnt !== 3'd2) $display("FAIL prefill_cnt: got %0d want 2", fifo_cnt); else n_pass++;
    mode = 2'd3;
    @(negedge clk);
    n_tot++; if (fifo_cnt !== 3'd0) $display("FAIL flush_on_idle: got %0d want 0", fifo_cnt); else n_pass++;
    din = 8'h55; d_rdy = 1'b1;
    @(negedge clk);
    d_rdy = 1'b0; tx_rdy = 1'b1;
    repeat (4) @(negedge clk);
    n_tot++; if (fifo_cnt !== 3'd0) $display("FAIL idle_drop_cnt: got %0d want 0", fifo_cnt); else n_pass++;
    n_tot++; if (ovf !== 1'b0)      $display("FAIL idle_drop_ovf: got %0b want 0", ovf); else n_pass++;
    n_tot++; if (q_b.size() !== 1)  $display("FAIL idle_sends_nothing: got %0d bytes want 1", q_b.size()); else n_pass++;
    mode = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [7:0] e [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB7};
    logic [7:0] gb;
    mode = 2'd0; tx_rdy = 1'b0;
    clear_q();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      din = 8'hA0 + 8'(i); d_rdy = 1'b1;
      @(negedge clk);
    end
    d_rdy = 1'b0;
    @(negedge clk);
    n_tot++; if (fifo_cnt !== 3'd4) $display("FAIL ovf_cnt_full: got %0d want 4", fifo_cnt); else n_pass++;
    n_tot++; if (ovf !== 1'b1)      $display("FAIL ovf_set: got %0b want 1", ovf); else n_pass++;
    n_tot++; if (q_b.size() !== 0)  $display("FAIL ovf_no_tx_while_blocked: got %0d bytes want 0", q_b.size()); else n_pass++;
    tx_rdy = 1'b1;
    @(negedge clk);
    n_tot++; if (tx_en !== 1'b1) $display("FAIL ovf_first_send: got %0b want 1", tx_en); else n_pass++;
    din = 8'hB7; d_rdy = 1'b1;
    @(negedge clk);
    d_rdy = 1'b0;
    n_tot++; if (fifo_cnt !== 3'd4) $display("FAIL full_push_pop_cnt: got %0d want 4", fifo_cnt); else n_pass++;
    repeat (20) @(negedge clk);
    n_tot++; if (q_b.size() !== 5) $display("FAIL ovf_sent_count: got %0d want 5", q_b.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      gb = (i < q_b.size()) ? q_b[i] : 8'hxx;
      n_tot++; if (gb !== e[i]) $display("FAIL ovf_byte%0d: got %0h want %0h", i, gb, e[i]); else n_pass++;
    end
    n_tot++; if (ovf !== 1'b1)      $display("FAIL ovf_sticky: got %0b want 1", ovf); else n_pass++;
    n_tot++; if (fifo_cnt !== 3'd0) $display("FAIL ovf_drained: got %0d want 0", fifo_cnt); else n_pass++;
  endtask

  task automatic test_msg(output int e);
    string m = "Hello, world!\r\n";
    logic [7:0] gb;
    int gc;
    tx_rdy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      msg_we = 1'b1; msg_addr = 5'(i); msg_wdata = m[i];
      @(negedge clk);
    end
    msg_we = 1'b0; msg_len = 6'd15;
    clear_q();
    mode = 2'd1; e = cyc;
    go_to(e + 100);
    n_tot++; if (busy !== 1'b0) $display("FAIL msg_busy_early: got %0b want 0", busy); else n_pass++;
    go_to(e + 200);
    n_tot++; if (busy !== 1'b0) $display("FAIL msg_busy_at_tick: got %0b want 0", busy); else n_pass++;
    go_to(e + 201);
    n_tot++; if (busy !== 1'b1) $display("FAIL msg_busy_after_tick: got %0b want 1", busy); else n_pass++;
    go_to(e + 244);
    n_tot++; if (busy !== 1'b1) $display("FAIL msg_busy_last_send: got %0b want 1", busy); else n_pass++;
    go_to(e + 245);
    n_tot++; if (busy !== 1'b0) $display("FAIL msg_busy_drop: got %0b want 0", busy); else n_pass++;
    go_to(e + 300);
    n_tot++; if (q_b.size() !== 15) $display("FAIL msg_count: got %0d want 15", q_b.size()); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      gb = (i < q_b.size()) ? q_b[i] : 8'hxx;
      gc = (i < q_c.size()) ? q_c[i] : -1;
      n_tot++; if (gb !== m[i])          $display("FAIL msg_byte%0d: got %0h want %0h", i, gb, m[i]); else n_pass++;
      n_tot++; if (gc !== e + 202 + 3*i) $display("FAIL msg_cycle%0d: got %0d want %0d", i, gc - e, 202 + 3*i); else n_pass++;
    end
    go_to(e + 450);
    n_tot++; if (q_b.size() !== 30) $display("FAIL msg_second_count: got %0d want 30", q_b.size()); else n_pass++;
    gc = (q_c.size() > 15) ? q_c[15] : -1;
    n_tot++; if (gc !== e + 402) $display("FAIL msg_second_start: got %0d want %0d", gc - e, 402); else n_pass++;
    gb = (q_b.size() > 29) ? q_b[29] : 8'hxx;
    n_tot++; if (gb !== 8'h0A) $display("FAIL msg_second_last: got %0h want 0a", gb); else n_pass++;
  endtask

  task automatic test_abort(input int e);
    string m = "Hello";
    logic [7:0] gb;
    go_to(e + 590);
    clear_q();
    go_to(e + 615);
    mode = 2'd0;
    go_to(e + 616);
    n_tot++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b want 0", busy); else n_pass++;
    go_to(e + 700);
    n_tot++; if (q_b.size() !== 5) $display("FAIL abort_count: got %0d want 5", q_b.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      gb = (i < q_b.size()) ? q_b[i] : 8'hxx;
      n_tot++; if (gb !== m[i]) $display("FAIL abort_byte%0d: got %0h want %0h", i, gb, m[i]); else n_pass++;
    end
  endtask

  task automatic test_zero_len;
    int e2;
    msg_len = 6'd0; mode = 2'd3;
    @(negedge clk);
    mode = 2'd1; e2 = cyc;
    clear_q();
    go_to(e2 + 3*PERIOD + 20);
    n_tot++; if (q_b.size() !== 0) $display("FAIL zero_len_tx: got %0d bytes want 0", q_b.size()); else n_pass++;
    n_tot++; if (busy !== 1'b0)    $display("FAIL zero_len_busy: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_flow(output int e);
    int viol = 0;
    int cd = 0;
    logic [7:0] gb;
    int gc;
    for (int i = 0; i < 32; i++) begin
      msg_we = 1'b1; msg_addr = 5'(i); msg_wdata = 8'h20 + 8'(i);
      @(negedge clk);
    end
    msg_we = 1'b0; msg_len = 6'd40; mode = 2'd3;
    @(negedge clk);
    mode = 2'd1; e = cyc; tx_rdy = 1'b1;
    clear_q();
    while (cyc < e + 590) begin
      @(negedge clk);
      if (tx_en === 1'b1 && tx_rdy !== 1'b1) viol++;
      if (tx_en === 1'b1) begin
        tx_rdy = 1'b0; cd = 8;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_rdy = 1'b1;
      end
    end
    tx_rdy = 1'b1;
    n_tot++; if (viol !== 0) $display("FAIL flow_tx_without_rdy: got %0d want 0", viol); else n_pass++;
    n_tot++; if (q_b.size() !== 32) $display("FAIL flow_count_clamped: got %0d want 32", q_b.size()); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      gb = (i < q_b.size()) ? q_b[i] : 8'hxx;
      gc = (i < q_c.size()) ? q_c[i] : -1;
      n_tot++; if (gb !== 8'h20 + 8'(i)) $display("FAIL flow_byte%0d: got %0h want %0h", i, gb, 8'h20 + 8'(i)); else n_pass++;
      n_tot++; if (gc !== e + 202 + 9*i)  $display("FAIL flow_cycle%0d: got %0d want %0d", i, gc - e, 202 + 9*i); else n_pass++;
    end
    n_tot++; if (busy !== 1'b0) $display("FAIL flow_busy_end: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_rst_mid(input int e);
    go_to(e + 602);
    n_tot++; if (tx_en !== 1'b1) $display("FAIL rst_pre_tx_en: got %0b want 1", tx_en); else n_pass++;
    n_tot++; if (busy !== 1'b1)  $display("FAIL rst_pre_busy: got %0b want 1", busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_tot++; if (dout !== 8'h00)    $display("FAIL rst_mid_dout: got %0h want 0", dout); else n_pass++;
    n_tot++; if (tx_en !== 1'b0)    $display("FAIL rst_mid_tx_en: got %0b want 0", tx_en); else n_pass++;
    n_tot++; if (busy !== 1'b0)     $display("FAIL rst_mid_busy: got %0b want 0", busy); else n_pass++;
    n_tot++; if (fifo_cnt !== 3'd0) $display("FAIL rst_mid_fifo_cnt: got %0d want 0", fifo_cnt); else n_pass++;
    n_tot++; if (ovf !== 1'b0)      $display("FAIL rst_mid_ovf: got %0b want 0", ovf); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e;
    mode = 2'd0; din = '0; d_rdy = 1'b0; tx_rdy = 1'b1;
    msg_we = 1'b0; msg_addr = '0; msg_wdata = '0; msg_len = '0;
    test_reset();
    test_echo();
    test_upper();
    test_idle_flush();
    test_overflow();
    test_msg(e);
    test_abort(e);
    test_zero_len();
    test_flow(e);
    test_rst_mid(e);
    n_tot++; if (n_consec !== 0) $display("FAIL back_to_back_tx_en: got %0d want 0", n_consec); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
